// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
//   tx_state_e : transmitter FSM state encoding
//   len_clamp  : limits a requested bit count to the register width
package seq_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } tx_state_e;

  function automatic int len_clamp(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable WIDTH-bit shift register feeding the serial output.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears the register)
//   load        : capture load_data[load_len-1:0] (justified for the send order)
//   shift_en    : advance one bit toward the emit position
//   load_data   : parallel word
//   load_len    : number of meaningful bits in load_data (1..WIDTH when loading)
//   load_head   : bit that sits at the emit position right after a load
//   shift_head  : bit that sits at the emit position right after a shift
module seq_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int LW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             load_head,
  output logic             shift_head
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mask, load_val, shift_val;

  always_comb begin
    mask = {WIDTH{1'b1}} >> (WIDTH - int'(load_len));
    // MSB-first left-justifies so the top meaningful bit lands at the emit end.
    load_val  = MSB_FIRST ? ((load_data & mask) << (WIDTH - int'(load_len)))
                          : (load_data & mask);
    shift_val = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

    load_head  = MSB_FIRST ? load_val[WIDTH-1]  : load_val[0];
    shift_head = MSB_FIRST ? shift_val[WIDTH-1] : shift_val[0];

    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = shift_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word plus bit count over
// valid/ready and emits it one bit per clock on x with x_valid / x_last framing.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : word offered;  in_ready : word accepted at this edge if valid
//   in_data   : pattern bits;  in_len   : bit count (0 = empty, >WIDTH clamped)
//   abort     : drop the word in flight (also blocks acceptance this cycle)
//   x, x_valid, x_last : registered serial bit and framing
//   busy      : FSM not idle
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH+1)-1:0] in_len,
  input  logic                       abort,
  output logic                       x,
  output logic                       x_valid,
  output logic                       x_last,
  output logic                       busy
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  tx_state_e     state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d, len_eff;
  logic [GW-1:0] gap_q, gap_d;
  logic          x_q, x_d, x_valid_q, x_valid_d, x_last_q, x_last_d;
  logic          load, shift_en, load_head, shift_head, accept;

  assign len_eff = LW'(len_clamp(int'(in_len), WIDTH));

  seq_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .LW        (LW)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift_en   (shift_en),
    .load_data  (in_data),
    .load_len   (len_eff),
    .load_head  (load_head),
    .shift_head (shift_head)
  );

  // cnt_q counts the bits still to be shown, including the one currently on x.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    x_last_d  = 1'b0;
    in_ready  = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;

    unique case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_SHIFT: begin
        if (cnt_q > LW'(1)) begin
          shift_en  = 1'b1;
          cnt_d     = cnt_q - LW'(1);
          x_d       = shift_head;
          x_valid_d = 1'b1;
          x_last_d  = (cnt_q == LW'(2));
        end else begin
          cnt_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP);
          end else begin
            state_d  = S_IDLE;
            in_ready = 1'b1;  // last bit on x: next word may follow seamlessly
          end
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort and reset both take priority over any handshake.
    if (rst || abort) begin
      in_ready = 1'b0;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      gap_d     = '0;
      shift_en  = 1'b0;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      x_last_d  = 1'b0;
    end

    // An empty word is consumed without leaving IDLE.
    accept = in_valid && in_ready;
    if (accept && (len_eff != '0)) begin
      load      = 1'b1;
      shift_en  = 1'b0;
      state_d   = S_SHIFT;
      cnt_d     = len_eff;
      x_d       = load_head;
      x_valid_d = 1'b1;
      x_last_d  = (len_eff == LW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign x_last  = x_last_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: three instances (MSB-first/no gap, LSB-first/no gap,
// MSB-first/gap 2) share one stimulus stream; each is compared every cycle
// against a slot-queue reference model.
module tb_seq_pattern_tx;

  localparam int W = 8;
  localparam bit MSBS[3] = '{1'b1, 1'b0, 1'b1};
  localparam int GAPS[3] = '{0, 0, 2};

  logic       clk = 1'b0;
  logic       rst, in_valid, abort;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic [2:0] x_w, xv_w, xl_w, rdy_w, busy_w;
  logic [2:0] smp_x, smp_xl;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .MSB_FIRST(MSBS[0]), .GAP(GAPS[0])) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]), .in_data(in_data),
    .in_len(in_len), .abort(abort), .x(x_w[0]), .x_valid(xv_w[0]), .x_last(xl_w[0]),
    .busy(busy_w[0]));
  seq_pattern_tx #(.WIDTH(W), .MSB_FIRST(MSBS[1]), .GAP(GAPS[1])) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]), .in_data(in_data),
    .in_len(in_len), .abort(abort), .x(x_w[1]), .x_valid(xv_w[1]), .x_last(xl_w[1]),
    .busy(busy_w[1]));
  seq_pattern_tx #(.WIDTH(W), .MSB_FIRST(MSBS[2]), .GAP(GAPS[2])) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]), .in_data(in_data),
    .in_len(in_len), .abort(abort), .x(x_w[2]), .x_valid(xv_w[2]), .x_last(xl_w[2]),
    .busy(busy_w[2]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: each DUT has a "current slot" (what the outputs show now)
  // and a FIFO of future slots. Slot code: 0 idle, 8 gap, 4|x<<1|last a bit.
  int cur[3];
  int mq[3][32];
  int mh[3];
  int mn[3];

  function automatic int kind(input int v);
    return v >> 2;
  endfunction

  function automatic bit model_ready(input int d);
    if (rst || abort || mn[d] != 0) return 1'b0;
    return (kind(cur[d]) == 0) || (GAPS[d] == 0 && kind(cur[d]) == 1);
  endfunction

  task automatic push(input int d, input int v);
    mq[d][(mh[d] + mn[d]) % 32] = v;
    mn[d]++;
  endtask

  task automatic model_edge(input int d, input bit acc);
    int le;
    int b;
    if (rst || (abort && kind(cur[d]) != 0)) begin
      cur[d] = 0;
      mn[d]  = 0;
    end else begin
      if (acc) begin
        le = (int'(in_len) > W) ? W : int'(in_len);
        for (int i = 0; i < le; i++) begin
          b = MSBS[d] ? int'(in_data[le-1-i]) : int'(in_data[i]);
          push(d, 4 + b * 2 + ((i == le - 1) ? 1 : 0));
        end
        if (le > 0) for (int g = 0; g < GAPS[d]; g++) push(d, 8);
      end
      if (mn[d] > 0) begin
        cur[d] = mq[d][mh[d]];
        mh[d]  = (mh[d] + 1) % 32;
        mn[d]--;
      end else begin
        cur[d] = 0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit acc[3];
    @(negedge clk);
    smp_x  = x_w;
    smp_xl = xl_w;
    for (int d = 0; d < 3; d++) begin
      acc[d] = model_ready(d) && in_valid;
      check($sformatf("d%0d in_ready", d), int'(rdy_w[d]), int'(model_ready(d)));
      check($sformatf("d%0d x", d), int'(x_w[d]), (cur[d] >> 1) & 1);
      check($sformatf("d%0d x_valid", d), int'(xv_w[d]), (kind(cur[d]) == 1) ? 1 : 0);
      check($sformatf("d%0d x_last", d), int'(xl_w[d]), cur[d] & 1);
      check($sformatf("d%0d busy", d), int'(busy_w[d]), (kind(cur[d]) != 0) ? 1 : 0);
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d, acc[d]);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] data, input logic [3:0] len);
    in_data  = data;
    in_len   = len;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  logic [4:0] cap0, cap1;
  logic [7:0] capx, capl;

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = '0; in_len = '0;
    for (int d = 0; d < 3; d++) begin cur[d] = 0; mh[d] = 0; mn[d] = 0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Reset held for two idle cycles, offering a word meanwhile.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h0F; in_len = 4'd4;
    cycle(); cycle();
    idle(2);

    // 0x0B, 5 bits, both orders.
    send(8'h0B, 4'd5);
    cap0 = '0; cap1 = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      cap0 = {cap0[3:0], smp_x[0]};
      cap1 = {cap1[3:0], smp_x[1]};
    end
    check("msb_first_0x0B", int'(cap0), 5'b01011);
    check("lsb_first_0x0B", int'(cap1), 5'b11010);
    idle(6);

    // Empty word and over-length word.
    send(8'hFF, 4'd0);
    idle(3);
    send(8'hA5, 4'd12);
    idle(14);

    // Back-to-back 4'h5 then 4'hA with in_valid held.
    in_data = 8'h05; in_len = 4'd4; in_valid = 1'b1;
    cycle();
    in_data = 8'h0A;
    capx = '0; capl = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      capx = {capx[6:0], smp_x[0]};
      capl = {capl[6:0], smp_xl[0]};
      if (k == 3) in_valid = 1'b0;
    end
    check("b2b_x", int'(capx), 8'b0101_1010);
    check("b2b_last", int'(capl), 8'b0001_0001);
    idle(8);

    // Abort after two bits, then reset after two bits.
    send(8'hFF, 4'd8);
    cycle(); cycle();
    abort = 1'b1; cycle();
    idle(4);
    send(8'hFF, 4'd8);
    cycle(); cycle();
    rst = 1'b1; cycle();
    idle(4);

    // Abort coinciding with an offer while idle.
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hC3; in_len = 4'd8;
    cycle();
    idle(4);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom);
      in_len   = 4'($urandom_range(0, 15));
      abort    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
